// File: rtl/vec_batchnorm_if.sv
// Upstream chunk handshake, downstream chunk handshake and coefficient port for vec_batchnorm.
// The master modport is the integrator side; the slave modport is the requantizer itself.
interface vec_batchnorm_if #(
    parameter int InVecLength = 8,
    parameter int WorkingRegs = 4
);
    localparam int AddrW = (InVecLength > 1) ? $clog2(InVecLength) : 1;

    logic                        in_data_ready;
    logic [WorkingRegs-1:0][7:0] in_data;
    logic                        req_chunk_in;
    logic [WorkingRegs-1:0][7:0] write_out_data;
    logic                        req_chunk_out;
    logic                        out_vector_valid;
    logic                        coef_wr_en;
    logic [AddrW-1:0]            coef_addr;
    logic [7:0]                  coef_scale;
    logic [15:0]                 coef_bias;
    logic                        coef_busy;

    modport master (
        output in_data_ready, in_data, coef_wr_en, coef_addr, coef_scale, coef_bias,
        input  req_chunk_in, write_out_data, req_chunk_out, out_vector_valid, coef_busy
    );

    modport slave (
        input  in_data_ready, in_data, coef_wr_en, coef_addr, coef_scale, coef_bias,
        output req_chunk_in, write_out_data, req_chunk_out, out_vector_valid, coef_busy
    );
endinterface

// File: rtl/vec_batchnorm.sv
// Per-element affine requantizer: y = sat8(round((x*scale[i] + bias[i]) >>> Shift)),
// pulling int8 chunks from the input FIFO and pushing results through a 2-stage pipeline.
module vec_batchnorm #(
    parameter int InVecLength = 8,
    parameter int WorkingRegs = 4,
    parameter int Shift       = 0
) (
    input  logic           clk_in,
    input  logic           rst_in,
    vec_batchnorm_if.slave bus
);
    localparam int NumChunks = InVecLength / WorkingRegs;
    localparam int CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam int AddrW     = (InVecLength > 1) ? $clog2(InVecLength) : 1;
    localparam logic signed [17:0] Round = 18'((1 << Shift) >> 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [CntW-1:0]             in_chunk_q, in_chunk_d;
    logic                        req_in_q, req_in_d;
    logic                        s1_valid_q, s1_valid_d;
    logic [CntW-1:0]             s1_chunk_q, s1_chunk_d;
    logic signed [15:0]          prod_q [WorkingRegs];
    logic signed [15:0]          prod_d [WorkingRegs];
    logic [WorkingRegs-1:0][7:0] out_q, out_d;
    logic                        req_out_q, req_out_d;
    logic                        ovv_q, ovv_d;
    logic signed [7:0]           scale_q [InVecLength];
    logic signed [7:0]           scale_d [InVecLength];
    logic signed [15:0]          bias_q [InVecLength];
    logic signed [15:0]          bias_d [InVecLength];

    function automatic logic [AddrW-1:0] elem_idx(input logic [CntW-1:0] chunk, input int lane);
        return AddrW'(int'(chunk) * WorkingRegs + lane);
    endfunction

    // Wide accumulator so product + bias + round term never wraps before saturation.
    function automatic logic [7:0] requant(input logic signed [15:0] prod,
                                           input logic signed [15:0] bias);
        logic signed [17:0] acc;
        acc = 18'(prod) + 18'(bias) + Round;
        acc = acc >>> Shift;
        if (acc > 18'sd127) return 8'h7f;
        if (acc < -18'sd128) return 8'h80;
        return acc[7:0];
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_chunk_d = in_chunk_q;
        req_in_d   = 1'b0;
        ovv_d      = ovv_q;
        case (state_q)
            IDLE: begin
                if (bus.in_data_ready) begin
                    state_d = READ;
                    cnt_d   = '0;
                    ovv_d   = 1'b0;
                end
            end
            READ: begin
                req_in_d   = 1'b1;
                in_chunk_d = cnt_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CntW'(NumChunks - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (!req_in_q && !s1_valid_q) begin
                    ovv_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scale_d = scale_q;
        bias_d  = bias_q;
        if (bus.coef_wr_en && state_q == IDLE && int'(bus.coef_addr) < InVecLength) begin
            scale_d[bus.coef_addr] = bus.coef_scale;
            bias_d[bus.coef_addr]  = bus.coef_bias;
        end
    end

    // Stage 1: the head chunk is sampled in the same cycle it is popped.
    always_comb begin
        prod_d     = prod_q;
        s1_chunk_d = s1_chunk_q;
        s1_valid_d = req_in_q;
        if (req_in_q) begin
            s1_chunk_d = in_chunk_q;
            for (int j = 0; j < WorkingRegs; j++) begin
                prod_d[j] = $signed(bus.in_data[j]) * scale_q[elem_idx(in_chunk_q, j)];
            end
        end
    end

    // Stage 2: write_out_data only changes when a result is pushed downstream.
    always_comb begin
        out_d     = out_q;
        req_out_d = s1_valid_q;
        if (s1_valid_q) begin
            for (int j = 0; j < WorkingRegs; j++) begin
                out_d[j] = requant(prod_q[j], bias_q[elem_idx(s1_chunk_q, j)]);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_chunk_q <= '0;
            req_in_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            req_out_q  <= 1'b0;
            out_q      <= '0;
            ovv_q      <= 1'b0;
            // NOTE: the coefficient file is reset on purpose: reset must restore the identity mapping.
            for (int i = 0; i < InVecLength; i++) begin
                scale_q[i] <= 8'sd1;
                bias_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_chunk_q <= in_chunk_d;
            req_in_q   <= req_in_d;
            s1_valid_q <= s1_valid_d;
            req_out_q  <= req_out_d;
            out_q      <= out_d;
            ovv_q      <= ovv_d;
            scale_q    <= scale_d;
            bias_q     <= bias_d;
        end
    end

    // NOTE: pipeline data regs have no reset; their valid bits gate every use of them.
    always_ff @(posedge clk_in) begin
        prod_q     <= prod_d;
        s1_chunk_q <= s1_chunk_d;
    end

    assign bus.req_chunk_in     = req_in_q;
    assign bus.write_out_data   = out_q;
    assign bus.req_chunk_out    = req_out_q;
    assign bus.out_vector_valid = ovv_q;
    assign bus.coef_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_vec_batchnorm.sv
// Randomized self-checking bench for vec_batchnorm: two instances (Shift 0 and 2) run in lockstep
// against an integer reference model, a FIFO model and a per-cycle handshake timing model.
module tb_vec_batchnorm;
    localparam int VL     = 8;
    localparam int WR     = 4;
    localparam int NC     = VL / WR;
    localparam int Period = NC + 4;

    typedef logic [WR-1:0][7:0] chunk_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic in_data_ready;
    logic coef_wr_en;
    logic [2:0] coef_addr;
    logic [7:0] coef_scale;
    logic [15:0] coef_bias;

    always #5 clk_in = ~clk_in;

    vec_batchnorm_if #(.InVecLength(VL), .WorkingRegs(WR)) bus0 ();
    vec_batchnorm_if #(.InVecLength(VL), .WorkingRegs(WR)) bus1 ();

    vec_batchnorm #(.InVecLength(VL), .WorkingRegs(WR), .Shift(0)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus0));
    vec_batchnorm #(.InVecLength(VL), .WorkingRegs(WR), .Shift(2)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus1));

    // Upstream FIFO model: head chunk is chunk_mem[rd_ptr], popped on each req_chunk_in.
    chunk_t     chunk_mem [256];
    logic [7:0] rd_ptr = '0;
    logic [7:0] wr_ptr = '0;

    assign bus0.in_data_ready = in_data_ready;
    assign bus1.in_data_ready = in_data_ready;
    assign bus0.in_data       = chunk_mem[rd_ptr];
    assign bus1.in_data       = chunk_mem[rd_ptr];
    assign bus0.coef_wr_en    = coef_wr_en;
    assign bus1.coef_wr_en    = coef_wr_en;
    assign bus0.coef_addr     = coef_addr;
    assign bus1.coef_addr     = coef_addr;
    assign bus0.coef_scale    = coef_scale;
    assign bus1.coef_scale    = coef_scale;
    assign bus0.coef_bias     = coef_bias;
    assign bus1.coef_bias     = coef_bias;

    always @(posedge clk_in) if (bus0.req_chunk_in) rd_ptr <= rd_ptr + 8'd1;

    chunk_t got0[$], got1[$], exp0[$], exp1[$], seen0[$], seen1[$];

    always @(negedge clk_in) begin
        if (bus0.req_chunk_out) got0.push_back(bus0.write_out_data);
        if (bus1.req_chunk_out) got1.push_back(bus1.write_out_data);
    end

    int scale_m [VL];
    int bias_m  [VL];
    int stim    [2][VL];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_y(input int x, input int s, input int b, input int sh);
        int t;
        t = x * s + b;
        if (sh > 0) t = t + (1 << (sh - 1));
        t = t >>> sh;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return 8'(t);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < VL; i++) begin
            scale_m[i] = 1;
            bias_m[i]  = 0;
        end
    endtask

    task automatic coef_write(input int addr, input int s, input int b);
        @(negedge clk_in);
        coef_wr_en = 1'b1;
        coef_addr  = 3'(addr);
        coef_scale = 8'(s);
        coef_bias  = 16'(b);
        @(negedge clk_in);
        coef_wr_en = 1'b0;
        scale_m[addr] = s;
        bias_m[addr]  = b;
    endtask

    // wr_mode: 0 none, 1 coefficient write on the IDLE->READ edge, 2 write while busy.
    task automatic run_vectors(input string name, input int nvec, input int wr_mode,
                               input int waddr, input int wscale, input int wbias);
        logic [63:0] rin0, rin1, rout0, rout1, ovv0, ovv1, busy0, busy1;
        logic [63:0] e_rin, e_rout, e_ovv, e_busy;
        chunk_t e0, e1;
        int win;
        win = nvec * Period + 2;
        {rin0, rin1, rout0, rout1, ovv0, ovv1, busy0, busy1} = '0;
        {e_rin, e_rout, e_ovv, e_busy} = '0;
        for (int v = 0; v < nvec; v++)
            for (int c = 0; c < NC; c++) begin
                for (int j = 0; j < WR; j++) chunk_mem[wr_ptr][j] = 8'(stim[v][c*WR+j]);
                wr_ptr = wr_ptr + 8'd1;
            end
        @(negedge clk_in);
        in_data_ready = 1'b1;
        if (wr_mode == 1) begin
            coef_wr_en = 1'b1;
            coef_addr  = 3'(waddr);
            coef_scale = 8'(wscale);
            coef_bias  = 16'(wbias);
            scale_m[waddr] = wscale;
            bias_m[waddr]  = wbias;
        end
        for (int v = 0; v < nvec; v++)
            for (int c = 0; c < NC; c++) begin
                for (int j = 0; j < WR; j++) begin
                    e0[j] = ref_y(stim[v][c*WR+j], scale_m[c*WR+j], bias_m[c*WR+j], 0);
                    e1[j] = ref_y(stim[v][c*WR+j], scale_m[c*WR+j], bias_m[c*WR+j], 2);
                end
                exp0.push_back(e0);
                exp1.push_back(e1);
            end
        for (int n = 0; n < win; n++) begin
            int v, k;
            @(negedge clk_in);
            v = n / Period;
            k = n % Period;
            e_rin[n]  = (v < nvec) && (k >= 1) && (k <= NC);
            e_rout[n] = (v < nvec) && (k >= 3) && (k <= NC + 2);
            e_busy[n] = (v < nvec) && (k <= NC + 2);
            e_ovv[n]  = (v >= nvec) || (k == NC + 3);
            rin0[n] = bus0.req_chunk_in;      rin1[n] = bus1.req_chunk_in;
            rout0[n] = bus0.req_chunk_out;    rout1[n] = bus1.req_chunk_out;
            ovv0[n] = bus0.out_vector_valid;  ovv1[n] = bus1.out_vector_valid;
            busy0[n] = bus0.coef_busy;        busy1[n] = bus1.coef_busy;
            if (n == 0) coef_wr_en = 1'b0;
            if (wr_mode == 2 && n == 2) begin
                coef_wr_en = 1'b1;
                coef_addr  = 3'(waddr);
                coef_scale = 8'(wscale);
                coef_bias  = 16'(wbias);
            end
            if (wr_mode == 2 && n == 3) coef_wr_en = 1'b0;
            if (n == (nvec - 1) * Period) in_data_ready = 1'b0;
        end
        check({name, " req_chunk_in s0"}, rin0, e_rin);
        check({name, " req_chunk_in s2"}, rin1, e_rin);
        check({name, " req_chunk_out s0"}, rout0, e_rout);
        check({name, " req_chunk_out s2"}, rout1, e_rout);
        check({name, " out_vector_valid s0"}, ovv0, e_ovv);
        check({name, " out_vector_valid s2"}, ovv1, e_ovv);
        check({name, " coef_busy s0"}, busy0, e_busy);
        check({name, " coef_busy s2"}, busy1, e_busy);
        check({name, " chunk count s0"}, 64'(got0.size()), 64'(exp0.size()));
        check({name, " chunk count s2"}, 64'(got1.size()), 64'(exp1.size()));
        seen0 = got0;
        seen1 = got1;
        for (int k = 0; got0.size() > 0 && exp0.size() > 0; k++)
            check($sformatf("%s data s0[%0d]", name, k), got0.pop_front(), exp0.pop_front());
        for (int k = 0; got1.size() > 0 && exp1.size() > 0; k++)
            check($sformatf("%s data s2[%0d]", name, k), got1.pop_front(), exp1.pop_front());
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic reset_mid_vector();
        int rout_seen, ovv_seen, busy_seen;
        rout_seen = 0; ovv_seen = 0; busy_seen = 0;
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j < WR; j++) chunk_mem[wr_ptr][j] = 8'(rnd8());
            wr_ptr = wr_ptr + 8'd1;
        end
        @(negedge clk_in);
        in_data_ready = 1'b1;
        @(negedge clk_in);
        in_data_ready = 1'b0;
        @(negedge clk_in);
        check("rst_mid first req_chunk_in", 64'(bus0.req_chunk_in), 64'd1);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n > 0) @(negedge clk_in);
            if (bus0.req_chunk_out || bus1.req_chunk_out) rout_seen++;
            if (bus0.out_vector_valid || bus1.out_vector_valid) ovv_seen++;
            if (bus0.coef_busy || bus1.coef_busy) busy_seen++;
        end
        check("rst_mid req_chunk_out count", 64'(rout_seen), 64'd0);
        check("rst_mid out_vector_valid count", 64'(ovv_seen), 64'd0);
        check("rst_mid coef_busy count", 64'(busy_seen), 64'd0);
        model_reset();
        wr_ptr = rd_ptr;
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        chunk_t id_exp;
        rst_in        = 1'b1;
        in_data_ready = 1'b0;
        coef_wr_en    = 1'b0;
        coef_addr     = '0;
        coef_scale    = '0;
        coef_bias     = '0;
        model_reset();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        check("reset outputs s0", {bus0.req_chunk_in, bus0.req_chunk_out, bus0.out_vector_valid,
                                   bus0.coef_busy, bus0.write_out_data}, 64'd0);
        check("reset outputs s2", {bus1.req_chunk_in, bus1.req_chunk_out, bus1.out_vector_valid,
                                   bus1.coef_busy, bus1.write_out_data}, 64'd0);

        for (int i = 0; i < VL; i++) stim[0][i] = i - 4;
        run_vectors("identity", 1, 0, 0, 0, 0);
        check("identity chunk0", seen0[0], 64'h0000_0000_fffe_fdfc);
        check("identity chunk1", seen0[1], 64'h0000_0000_0302_0100);

        for (int i = 1; i < VL; i++) coef_write(i, 4, 0);
        coef_write(0, 3, -10);
        stim[0][0] = 20;
        stim[0][1] = -5;
        for (int i = 2; i < VL; i++) stim[0][i] = rnd8();
        run_vectors("affine", 1, 0, 0, 0, 0);
        check("affine x0 shift2", 64'(seen1[0][0]), 64'h0d);
        check("affine x1 shift2", 64'(seen1[0][1]), 64'hfb);

        for (int i = 0; i < VL; i++) coef_write(i, 127, (i == 2) ? 32767 : 0);
        stim[0][0] = 127;
        stim[0][1] = -128;
        stim[0][2] = 1;
        for (int i = 3; i < VL; i++) stim[0][i] = rnd8();
        run_vectors("saturate", 1, 0, 0, 0, 0);
        check("saturate +127", 64'(seen0[0][0]), 64'h7f);
        check("saturate -128", 64'(seen0[0][1]), 64'h80);
        check("saturate bias", 64'(seen0[0][2]), 64'h7f);

        for (int i = 0; i < VL; i++) stim[0][i] = rnd8();
        run_vectors("busy write", 1, 2, 0, 9, 0);
        stim[0][0] = 10;
        run_vectors("after busy write", 1, 0, 0, 0, 0);
        check("busy write dropped", 64'(seen0[0][0]), 64'h7f);
        coef_write(0, 9, 0);
        run_vectors("idle rewrite", 1, 0, 0, 0, 0);
        check("idle rewrite applied", 64'(seen0[0][0]), 64'h5a);
        run_vectors("write on entry", 1, 1, 1, -7, 100);

        for (int it = 0; it < 8; it++) begin
            coef_write(int'($urandom_range(VL - 1)), rnd8(), int'($urandom_range(65535)) - 32768);
            coef_write(int'($urandom_range(VL - 1)), rnd8(), int'($urandom_range(65535)) - 32768);
            for (int i = 0; i < VL; i++) stim[0][i] = rnd8();
            run_vectors($sformatf("random%0d", it), 1, it % 3, int'($urandom_range(VL - 1)),
                        rnd8(), int'($urandom_range(65535)) - 32768);
        end

        for (int v = 0; v < 2; v++)
            for (int i = 0; i < VL; i++) stim[v][i] = rnd8();
        run_vectors("back2back", 2, 0, 0, 0, 0);

        reset_mid_vector();
        for (int i = 0; i < VL; i++) stim[0][i] = rnd8();
        run_vectors("post reset", 1, 0, 0, 0, 0);
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j < WR; j++) id_exp[j] = 8'(stim[0][c*WR+j]);
            check($sformatf("post reset identity chunk%0d", c), seen0[c], id_exp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
